// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - core-wide widths shared by the fetch queue
package inst_fetch_queue_pkg;

  localparam int IMEM_ADDR_BIT = 10;
  localparam int INST_WIDTH    = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - pointers, occupancy and handshake logic of the fetch queue
module fetch_queue_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          push,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  // Handshakes depend only on registered occupancy and flush, never on out_ready.
  assign in_ready  = (count_q != CW'(DEPTH)) & ~flush;
  assign out_valid = (count_q != '0) & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - IF-to-ID fetch queue: storage array and output masking
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_BIT   = IMEM_ADDR_BIT,
  parameter int INST_BIT = INST_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_BIT-1:0]        in_pc_4,
  input  logic [INST_BIT-1:0]      in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_BIT-1:0]        out_pc_4,
  output logic [INST_BIT-1:0]      out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = PC_BIT + INST_BIT;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push;

  fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  // Storage is intentionally unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= {in_pc_4, in_inst};
  end

  assign head     = mem_q[rd_ptr];
  assign out_pc_4 = out_valid ? head[EW-1:INST_BIT] : '0;
  assign out_inst = out_valid ? head[INST_BIT-1:0]  : '0;

endmodule
